// File: rtl/counter_nbits.sv
// N-bit free-running binary up-counter with synchronous parallel load.
// Priority at each rising edge: reset, then load, then increment (mod 2^N).
module counter_nbits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] preset,
  output logic [N-1:0] out
);

  logic [N-1:0] r_count;
  logic [N-1:0] w_count_inc;

  // Carry out of the top bit is dropped, giving natural wrap from all-ones to zero.
  assign w_count_inc = r_count + N'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= preset;
    end else begin
      r_count <= w_count_inc;
    end
  end

  assign out = r_count;

endmodule

// File: tb/tb_counter_nbits.sv
// Self-checking bench for counter_nbits (N=5): directed scenarios plus a
// randomized run against a plain-arithmetic reference model.
module tb_counter_nbits;

  localparam int N = 5;
  localparam int MODULUS = 1 << N;

  logic         clk;
  logic         rst;
  logic         load;
  logic [N-1:0] preset;
  logic [N-1:0] out;

  int checks;
  int failures;
  int model_count;

  counter_nbits #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .preset(preset),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, apply the counter's rules to the model, then
  // let the DUT settle before the caller compares.
  task automatic tick();
    @(posedge clk);
    if (rst)
      model_count = 0;
    else if (load)
      model_count = int'(preset);
    else
      model_count = (model_count + 1) % MODULUS;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; preset = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== '0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: out=%0d expected=0", i, out);
      end
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; load = 1'b1; preset = 5'b11011;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out !== '0) begin
        failures++;
        $display("FAIL reset_over_load[%0d]: out=%0d expected=0", i, out);
      end
    end
  endtask

  task automatic test_load_hold();
    rst = 1'b0; load = 1'b1; preset = 5'd27;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 5'd27) begin
        failures++;
        $display("FAIL load_hold[%0d]: out=%0d expected=27", i, out);
      end
    end
  endtask

  task automatic test_wrap();
    int seq [7];
    seq = '{28, 29, 30, 31, 0, 1, 2};
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (out !== N'(seq[i])) begin
        failures++;
        $display("FAIL wrap_seq[%0d]: out=%0d expected=%0d", i, out, seq[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b0; load = 1'b1; preset = 5'd10;
    tick();
    load = 1'b0;
    tick();
    tick();
    checks++;
    if (out !== 5'd12) begin
      failures++;
      $display("FAIL mid_reset_pre: out=%0d expected=12", out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== '0) begin
      failures++;
      $display("FAIL mid_reset_pulse: out=%0d expected=0", out);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (out !== N'(i)) begin
        failures++;
        $display("FAIL mid_reset_resume[%0d]: out=%0d expected=%0d", i, out, i);
      end
    end
  endtask

  task automatic test_preset_track();
    int pv [4];
    pv = '{3, 17, 17, 6};
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      preset = N'(pv[i]);
      tick();
      checks++;
      if (out !== N'(pv[i])) begin
        failures++;
        $display("FAIL preset_track[%0d]: out=%0d expected=%0d", i, out, pv[i]);
      end
    end
    // Reset release with load high: the load wins on the first free edge.
    rst = 1'b1;
    tick();
    rst = 1'b0; preset = 5'd9;
    tick();
    checks++;
    if (out !== 5'd9) begin
      failures++;
      $display("FAIL release_with_load: out=%0d expected=9", out);
    end
    load = 1'b0;
    tick();
    checks++;
    if (out !== 5'd10) begin
      failures++;
      $display("FAIL release_then_count: out=%0d expected=10", out);
    end
  endtask

  task automatic test_between_edges();
    logic [N-1:0] held;
    held = out;
    #1 load = 1'b1; preset = 5'd21;
    #1 rst = 1'b1;
    #1 rst = 1'b0; load = 1'b0;
    checks++;
    if (out !== held) begin
      failures++;
      $display("FAIL between_edges: out=%0d expected=%0d", out, held);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 15) == 0);
      load   = ($urandom_range(0, 3) == 0);
      preset = N'($urandom);
      tick();
      checks++;
      if (out !== N'(model_count)) begin
        failures++;
        $display("FAIL random[%0d]: out=%0d expected=%0d", i, out, model_count);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_count = 0;
    rst = 1'b1; load = 1'b0; preset = '0;
    test_reset();
    test_reset_priority();
    test_load_hold();
    test_wrap();
    test_mid_reset();
    test_preset_track();
    test_between_edges();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
